// File: rtl/div_seq_pkg.sv
// Shared constants for the multi-cycle divider sequencer.
//
// Contents:
//   div_state_e        2-bit sequencer state (DivFree, DivByZero, DivOn, DivEnd)
//   DivStart/DivStop   encodings of the start_i request level
//   DivResultReady/DivResultNotReady
//                      encodings of the ready_o level
//   EXE_DIV_OP/EXE_DIVU_OP
//                      execute-stage ALU op codes that select this unit
//   DoubleRegBus       width of the {HI, LO} result bus
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int DoubleRegBus = 64;

endpackage : div_seq_pkg

// File: rtl/div_seq.sv
// Multi-cycle DW/DW divider sequencer for DIV/DIVU (radix-2 restoring,
// one quotient bit per clock). Operands are captured when a request is
// accepted, so execute may change them freely afterwards.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   signed_div_i  in   1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i     in   dividend; sampled with start_i
//   opdata2_i     in   divisor; sampled with start_i
//   start_i       in   divide request level, held until ready_o
//   annul_i       in   abort the divide in progress
//   result_o      out  {remainder, quotient}; valid only while ready_o=1
//   ready_o       out  result valid
//   busy_o        out  high in DivByZero and DivOn; execute stalls on it
//
// Handshake: execute raises start_i and holds it. ready_o rises with the
// result and stays high (value stable) for as long as start_i stays high.
// Dropping start_i returns the unit to idle on the next edge; a new
// request needs start_i low for at least one cycle in between.
//
// All outputs are decodes of registers; no input reaches an output
// combinationally.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW);

    function automatic logic [DW-1:0] neg(input logic [DW-1:0] v);
        return ~v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Partial remainder / dividend shift register. Bits [2DW:DW+1] hold
    // the remainder and [DW-1:0] the quotient once all iterations ran.
    logic [2*DW:0]    dvd_q, dvd_d;
    logic [DW-1:0]    dvs_q, dvs_d;
    logic             signed_q, signed_d;
    logic             op1_neg_q, op1_neg_d;
    logic             op2_neg_q, op2_neg_d;
    logic [2*DW-1:0]  result_q, result_d;

    // Operand magnitudes at capture time
    logic [DW-1:0]    op1_abs;
    logic [DW-1:0]    op2_abs;
    // Trial subtraction, one extra bit to expose the borrow
    logic [DW:0]      trial;
    logic [DW-1:0]    quo_fix;
    logic [DW-1:0]    rem_fix;
    logic             req_ok;

    assign req_ok  = (start_i == DivStart) && !annul_i;
    assign op1_abs = (signed_div_i && opdata1_i[DW-1]) ? neg(opdata1_i) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[DW-1]) ? neg(opdata2_i) : opdata2_i;
    assign trial   = {1'b0, dvd_q[2*DW-1:DW]} - {1'b0, dvs_q};

    // Sign correction: quotient takes the xor of the operand signs,
    // remainder takes the sign of the dividend.
    assign quo_fix = (signed_q && (op1_neg_q ^ op2_neg_q)) ? neg(dvd_q[DW-1:0]) : dvd_q[DW-1:0];
    assign rem_fix = (signed_q && op1_neg_q) ? neg(dvd_q[2*DW:DW+1]) : dvd_q[2*DW:DW+1];

    // ------------------------------------------------------------------
    // Process 1: registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            signed_q  <= 1'b0;
            op1_neg_q <= 1'b0;
            op2_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            signed_q  <= signed_d;
            op1_neg_q <= op1_neg_d;
            op2_neg_q <= op2_neg_d;
            result_q  <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (req_ok) begin
                    state_d = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_d = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (annul_i || (start_i == DivStop)) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        signed_d  = signed_q;
        op1_neg_d = op1_neg_q;
        op2_neg_d = op2_neg_q;
        result_d  = result_q;
        case (state_q)
            DivFree: begin
                result_d = '0;
                if (req_ok && (opdata2_i != '0)) begin
                    cnt_d     = '0;
                    dvd_d     = {{DW{1'b0}}, op1_abs, 1'b0};
                    dvs_d     = op2_abs;
                    signed_d  = signed_div_i;
                    op1_neg_d = signed_div_i && opdata1_i[DW-1];
                    op2_neg_d = signed_div_i && opdata2_i[DW-1];
                end
            end
            DivByZero: begin
                // No trap: software checks the divisor itself.
                result_d = '0;
            end
            DivOn: begin
                if (!annul_i) begin
                    if (cnt_q != CNT_LAST) begin
                        if (trial[DW]) begin
                            dvd_d = dvd_q << 1;
                        end else begin
                            dvd_d = {trial[DW-1:0], dvd_q[DW-1:0], 1'b1};
                        end
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            DivEnd: begin
                if (annul_i || (start_i == DivStop)) begin
                    result_d = '0;
                end
            end
            default: result_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs (pure decodes of registered state)
    // ------------------------------------------------------------------
    always_comb begin
        ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
        busy_o   = (state_q == DivByZero) || (state_q == DivOn);
        result_o = result_q;
    end

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Bench for div_seq: a table of divide vectors with fixed expected results,
// a batch of random vectors checked against a 64-bit arithmetic model, and
// hand-written sequences for annul, reset and handshake corner cases.
module tb_div_seq;

    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            signed_div_i;
    logic [DW-1:0]   opdata1_i;
    logic [DW-1:0]   opdata2_i;
    logic            start_i;
    logic            annul_i;
    logic [2*DW-1:0] result_o;
    logic            ready_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;

    logic [2*DW-1:0] exp_q[$];

    typedef struct {
        logic          sgn;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] quo;
        logic [DW-1:0] rem;
    } vec_t;

    vec_t vecs[10];

    div_seq #(.DW(DW), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] qv, rv;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            qv = sq;
            rv = sr;
            return {rv[31:0], qv[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Present a request; the next rising edge is E0.
    task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
    endtask

    // Wait for the result of a request whose E0 is the next edge, compare it
    // against the scoreboard, optionally hold start_i in END, then release.
    task automatic wait_result(input string name, input int exp_lat, input int hold);
        int n;
        int busy_n;
        logic got;
        logic [63:0] exp;
        logic [63:0] first;
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (!got && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                // Operands are no longer relevant once captured.
                signed_div_i = 1'($urandom_range(0, 1));
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
            end
            if (busy_o) busy_n++;
            if (ready_o) got = 1'b1;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: ready_o never rose, expected %h", name, exp);
        end else begin
            check({name, "_result"}, result_o, exp);
            check({name, "_latency"}, 64'(n - 1), 64'(exp_lat));
            check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat));
            first = result_o;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({name, "_hold_ready"}, 64'(ready_o), 64'd1);
                check({name, "_hold_result"}, result_o, first);
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_release_ready"}, 64'(ready_o), 64'd0);
        check({name, "_release_result"}, result_o, 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic seen_ready;
        logic sgn;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[3] = '{1'b1, 32'd5,          32'd0,        32'd0,         32'd0};
        vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0};
        vecs[6] = '{1'b0, 32'd9,          32'd3,        32'd3,         32'd0};
        vecs[7] = '{1'b0, 32'd3,          32'd9,        32'd0,         32'd3};
        vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[9] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32'd0};

        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            start_div(vecs[i].sgn, vecs[i].a, vecs[i].b);
            exp_q.push_back({vecs[i].rem, vecs[i].quo});
            wait_result($sformatf("vec%0d", i), (vecs[i].b == 0) ? 1 : 33, 0);
        end

        // Random vectors against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 20)) : $urandom;
            start_div(sgn, a, b);
            exp_q.push_back(model_div(sgn, a, b));
            wait_result($sformatf("rand%0d", i), (b == 0) ? 1 : 33, 0);
        end

        // start_i held high in END for 5 cycles
        start_div(1'b0, 32'd1000, 32'd33);
        exp_q.push_back({32'd10, 32'd30});
        wait_result("hold_end", 33, 5);

        // annul at iteration 10, then an immediate new request 9/3
        start_div(1'b0, 32'd100, 32'd7);
        seen_ready = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        if (ready_o) seen_ready = 1'b1;
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_no_ready", 64'(seen_ready), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        exp_q.push_back({32'd0, 32'd3});
        wait_result("after_annul", 33, 0);

        // reset at iteration 20, then clean restart
        start_div(1'b0, 32'd100, 32'd7);
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        exp_q.push_back({32'd0, 32'hFFFF_FFFF});
        wait_result("after_rst", 33, 0);

        // annul together with start in FREE: request ignored
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        annul_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("annul_free_busy", 64'(busy_o), 64'd0);
        check("annul_free_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;

        // annul while sitting in END returns to idle
        start_div(1'b0, 32'd50, 32'd5);
        exp_q.push_back({32'd0, 32'd10});
        wait_result("pre_end_annul", 33, 2);
        start_div(1'b0, 32'd20, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("end_annul_ready_before", 64'(ready_o), 64'd1);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("end_annul_ready_after", 64'(ready_o), 64'd0);
        check("end_annul_result", result_o, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (2) @(posedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_seq
